// File: rtl/id_hazard_fwd_unit.sv
// ID-stage operand bypass and load-use hazard unit: priority forwarding mux per read
// port, per-register countdown scoreboard for late results, and a stall-cycle counter.
module id_hazard_fwd_unit #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_FWD  = 3,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    hold_i,
    input  logic                    flush_i,
    input  logic [NUM_RD-1:0]       rd_en_i,
    input  logic [NUM_RD*AW-1:0]    rd_addr_i,
    input  logic [NUM_RD*DW-1:0]    rf_rdata_i,
    input  logic [NUM_FWD-1:0]      fwd_we_i,
    input  logic [NUM_FWD*AW-1:0]   fwd_waddr_i,
    input  logic [NUM_FWD*DW-1:0]   fwd_wdata_i,
    input  logic                    iss_valid_i,
    input  logic                    iss_late_i,
    input  logic [AW-1:0]           iss_waddr_i,
    output logic [NUM_RD*DW-1:0]    op_rdata_o,
    output logic                    stallreq_o,
    output logic [(2**AW)-1:0]      busy_vec_o,
    output logic [31:0]             stall_cycles_o
);
    localparam int NREG = 2**AW;

    logic [NREG-1:0][CW-1:0] cnt_q;
    logic [NREG-1:0][CW-1:0] cnt_d;
    logic [31:0]             stall_cycles_q;
    logic [31:0]             stall_cycles_d;
    logic [NUM_RD-1:0]       port_stall;
    logic                    issue_late;

    assign issue_late = iss_valid_i && !flush_i && iss_late_i && (iss_waddr_i != '0);

    // A fresh late issue overrides the countdown of the same register.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!hold_i && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
        if (issue_late) begin
            cnt_d[iss_waddr_i] = CW'(LOAD_LAT);
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            assign busy_vec_o[gi] = |cnt_q[gi];
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [AW-1:0] addr;
            logic [DW-1:0] sel;

            assign addr = rd_addr_i[gi*AW +: AW];

            // Scan from oldest to youngest so the lowest-index match is the last write.
            always_comb begin
                sel = rf_rdata_i[gi*DW +: DW];
                for (int j = NUM_FWD - 1; j >= 0; j--) begin
                    if (fwd_we_i[j] && (fwd_waddr_i[j*AW +: AW] == addr)) begin
                        sel = fwd_wdata_i[j*DW +: DW];
                    end
                end
                if (addr == '0) begin
                    sel = '0;
                end
            end

            assign op_rdata_o[gi*DW +: DW] = sel;
            assign port_stall[gi] = rd_en_i[gi] && (addr != '0) && (cnt_q[addr] != '0);
        end
    endgenerate

    assign stallreq_o = |port_stall;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stallreq_o && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Bench for id_hazard_fwd_unit: two instances (load latency 1 and 2) on shared stimulus,
// checked against a ready-time reference model plus directed literal expectations.
module tb_id_hazard_fwd_unit;
    localparam int DW = 32, AW = 5, NUM_RD = 2, NUM_FWD = 3, CW = 3, NREG = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n, hold, flush, iss_valid, iss_late;
    logic [NUM_RD-1:0]     rd_en;
    logic [NUM_RD*AW-1:0]  rd_addr;
    logic [NUM_RD*DW-1:0]  rf_rdata;
    logic [NUM_FWD-1:0]    fwd_we;
    logic [NUM_FWD*AW-1:0] fwd_waddr;
    logic [NUM_FWD*DW-1:0] fwd_wdata;
    logic [AW-1:0]         iss_waddr;

    logic [NUM_RD*DW-1:0]  op1, op2;
    logic                  st1, st2;
    logic [NREG-1:0]       busy1, busy2;
    logic [31:0]           sc1, sc2;

    id_hazard_fwd_unit #(.DW(DW), .AW(AW), .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD),
                         .LOAD_LAT(1), .CW(CW)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .hold_i(hold), .flush_i(flush),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rf_rdata_i(rf_rdata),
        .fwd_we_i(fwd_we), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
        .iss_valid_i(iss_valid), .iss_late_i(iss_late), .iss_waddr_i(iss_waddr),
        .op_rdata_o(op1), .stallreq_o(st1), .busy_vec_o(busy1), .stall_cycles_o(sc1));

    id_hazard_fwd_unit #(.DW(DW), .AW(AW), .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD),
                         .LOAD_LAT(2), .CW(CW)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .hold_i(hold), .flush_i(flush),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rf_rdata_i(rf_rdata),
        .fwd_we_i(fwd_we), .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
        .iss_valid_i(iss_valid), .iss_late_i(iss_late), .iss_waddr_i(iss_waddr),
        .op_rdata_o(op2), .stallreq_o(st2), .busy_vec_o(busy2), .stall_cycles_o(sc2));

    // Model: a register is busy until the count of non-hold edges reaches its ready time.
    int unsigned lat [2] = '{1, 2};
    int unsigned ready_at [2][NREG];
    int unsigned nh;
    longint      scnt [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_op(input int i);
        logic [AW-1:0] a;
        a = rd_addr[i*AW +: AW];
        if (a == '0) return '0;
        for (int j = 0; j < NUM_FWD; j++)
            if (fwd_we[j] && fwd_waddr[j*AW +: AW] == a) return fwd_wdata[j*DW +: DW];
        return rf_rdata[i*DW +: DW];
    endfunction

    function automatic bit m_busy(input int k, input int r);
        return (r != 0) && (ready_at[k][r] > nh);
    endfunction

    function automatic bit m_stall(input int k);
        for (int i = 0; i < NUM_RD; i++)
            if (rd_en[i] && m_busy(k, int'(rd_addr[i*AW +: AW]))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NREG-1:0] m_busyvec(input int k);
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = m_busy(k, r);
        return v;
    endfunction

    function automatic logic [31:0] m_sc(input int k);
        return (scnt[k] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : scnt[k][31:0];
    endfunction

    task automatic model_reset();
        nh = 0;
        scnt[0] = 0;
        scnt[1] = 0;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < NREG; r++) ready_at[k][r] = 0;
    endtask

    // One clock edge with the currently applied inputs; inputs may change again afterwards.
    task automatic tick();
        bit s0, s1;
        s0 = m_stall(0);
        s1 = m_stall(1);
        @(posedge clk);
        if (s0) scnt[0]++;
        if (s1) scnt[1]++;
        if (!hold) nh++;
        if (iss_valid && !flush && iss_late && iss_waddr != '0)
            for (int k = 0; k < 2; k++) ready_at[k][iss_waddr] = nh + lat[k];
        #1;
    endtask

    task automatic clear_inputs();
        hold = 0; flush = 0; iss_valid = 0; iss_late = 0; iss_waddr = '0;
        rd_en = '0; rd_addr = '0; rf_rdata = '0;
        fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
    endtask

    task automatic issue_late_to(input logic [AW-1:0] r);
        iss_valid = 1; iss_late = 1; iss_waddr = r;
        tick();
        iss_valid = 0; iss_late = 0; iss_waddr = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("op_rdata_lat1", op1, {m_op(1), m_op(0)});
            chk("op_rdata_lat2", op2, {m_op(1), m_op(0)});
            chk("stallreq_lat1", st1, m_stall(0));
            chk("stallreq_lat2", st2, m_stall(1));
            chk("busy_vec_lat1", busy1, m_busyvec(0));
            chk("busy_vec_lat2", busy2, m_busyvec(1));
            chk("stall_cycles_lat1", sc1, m_sc(0));
            chk("stall_cycles_lat2", sc2, m_sc(1));
            chk("env_no_issue_while_stalled", iss_valid & (st1 | st2), 0);
        end
    end

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("reset_stallreq", {st1, st2}, 0);
        chk("reset_busy_vec", {busy1, busy2}, 0);
        chk("reset_stall_cycles", {sc1, sc2}, 0);
        tick();

        // Priority forwarding on r5.
        rd_addr[0 +: AW] = 5'd5;
        rf_rdata[0 +: DW] = 32'h0000_AAAA;
        fwd_waddr = {5'd5, 5'd5, 5'd5};
        fwd_wdata = {32'h33, 32'h22, 32'h11};
        fwd_we = 3'b111;
        #1 chk("fwd_prio_ex", op1[0 +: DW], 32'h11);
        fwd_we = 3'b110;
        #1 chk("fwd_prio_mem", op1[0 +: DW], 32'h22);
        fwd_we = 3'b000;
        #1 chk("fwd_none_rf", op2[0 +: DW], 32'h0000_AAAA);
        tick();

        // r0 always reads zero and never becomes busy.
        clear_inputs();
        fwd_we = 3'b001; fwd_waddr[0 +: AW] = '0; fwd_wdata[0 +: DW] = 32'hDEAD;
        rf_rdata[0 +: DW] = 32'hBEEF;
        rd_en = 2'b01;
        #1 chk("r0_reads_zero", op1[0 +: DW], 32'h0);
        issue_late_to(5'd0);
        chk("r0_never_busy", {busy1, busy2}, 0);
        chk("r0_no_stall", {st1, st2}, 0);

        // Load-use on r8.
        clear_inputs();
        issue_late_to(5'd8);
        rd_en = 2'b01; rd_addr[0 +: AW] = 5'd8;
        #1 chk("loaduse_stall_lat1", st1, 1'b1);
        tick();
        chk("loaduse_clear_lat1", st1, 1'b0);
        chk("loaduse_count_lat1", sc1, 32'd1);
        fwd_we = 3'b010; fwd_waddr[AW +: AW] = 5'd8; fwd_wdata[DW +: DW] = 32'h55;
        #1 chk("loaduse_mem_fwd", op1[0 +: DW], 32'h55);
        chk("loaduse_fwd_no_suppress_lat2", st2, 1'b1);
        tick();
        chk("loaduse_clear_lat2", st2, 1'b0);
        chk("loaduse_count_lat2", sc2, 32'd2);

        // Hold freezes the countdown on r3.
        clear_inputs();
        issue_late_to(5'd3);
        rd_en = 2'b01; rd_addr[0 +: AW] = 5'd3;
        hold = 1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("hold_stall_kept", st2, 1'b1);
            tick();
        end
        hold = 0;
        #1 chk("hold_released_stall", st2, 1'b1);
        tick();
        chk("hold_one_left_stall", st2, 1'b1);
        tick();
        chk("hold_clears", st2, 1'b0);
        chk("hold_stall_count", sc2, 32'd7);

        // Flushed issue is dropped; reissue at count 1 reloads.
        clear_inputs();
        flush = 1;
        issue_late_to(5'd4);
        flush = 0;
        chk("flush_drops_issue", {busy1[4], busy2[4]}, 2'b00);
        issue_late_to(5'd4);
        tick();
        chk("reissue_count_one", busy2[4], 1'b1);
        issue_late_to(5'd4);
        tick();
        chk("reissue_reloaded", busy2[4], 1'b1);
        tick();
        chk("reissue_expired", busy2[4], 1'b0);

        // Asynchronous reset between edges.
        clear_inputs();
        issue_late_to(5'd9);
        rd_en = 2'b01; rd_addr[0 +: AW] = 5'd9;
        #1 chk("areset_pre_stall", {st1, st2}, 2'b11);
        rst_n = 0;
        model_reset();
        #1;
        chk("areset_stallreq", {st1, st2}, 0);
        chk("areset_busy_vec", {busy1, busy2}, 0);
        chk("areset_stall_cycles", {sc1, sc2}, 0);
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Randomized traffic with hazards concentrated on r0..r7.
        for (int n = 0; n < 3000; n++) begin
            rd_en = 2'($urandom);
            for (int i = 0; i < NUM_RD; i++)
                rd_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rf_rdata = {$urandom, $urandom};
            fwd_we = 3'($urandom);
            for (int j = 0; j < NUM_FWD; j++)
                fwd_waddr[j*AW +: AW] = 5'($urandom_range(0, 7));
            fwd_wdata = {$urandom, $urandom, $urandom};
            hold = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 4) == 0);
            iss_late = 1'($urandom);
            iss_waddr = 5'($urandom_range(0, 7));
            iss_valid = 1'($urandom) && !(m_stall(0) || m_stall(1));
            tick();
        end

        clear_inputs();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_hazard_fwd_unit.md
Name: id_hazard_fwd_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the ID stage of the 5-stage MIPS pipeline.
- Takes NUM_RD register-file read results and NUM_FWD forwarding sources (EX, MEM, WB, ...), and returns bypassed operands under fixed priority.
- Keeps a per-register countdown scoreboard for late-result instructions (loads, with configurable latency) and raises the ID stall request.
- Adds a saturating stall-cycle counter for performance debug.

Parameters:
DW, 32, data width
AW, 5, register address width; NREG = 2**AW
NUM_RD, 2, read ports (rs, rt)
NUM_FWD, 3, forwarding sources; index 0 = youngest (EX), highest priority
LOAD_LAT, 1, cycles after issue before a late result becomes forwardable (1..7)
CW, 3, scoreboard counter width; must hold LOAD_LAT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
hold  in  1  back-end freeze (EX and later stalled); scoreboard does not count down
flush  in  1  kill the ID instruction this cycle; suppresses iss_valid
rd_en  in  NUM_RD  read port i uses its operand
rd_addr  in  NUM_RD*AW  packed read addresses, port 0 in LSBs
rf_rdata  in  NUM_RD*DW  register-file read data
fwd_we  in  NUM_FWD  source j carries a valid write
fwd_waddr  in  NUM_FWD*AW  source write addresses
fwd_wdata  in  NUM_FWD*DW  source write data
iss_valid  in  1  ID instruction advances to EX this cycle
iss_late  in  1  issued instruction's result arrives late (load)
iss_waddr  in  AW  issued instruction's destination
op_rdata  out  NUM_RD*DW  bypassed operands
stallreq  out  1  load-use hazard; freeze IF/ID, insert bubble into EX
busy_vec  out  NREG  debug: bit r = counter r nonzero
stall_cycles  out  32  saturating count of cycles with stallreq=1

Behaviour:
- Reset (rst=0, asynchronous): all counters = 0, stall_cycles = 0, busy_vec = 0, stallreq = 0.
- op_rdata is combinational, per port i:
  - If rd_addr[i]==0, output 0. This applies regardless of forwarding sources and rf_rdata.
  - Otherwise, select the lowest j with fwd_we[j] && fwd_waddr[j]==rd_addr[i] and output fwd_wdata[j].
  - If no source matches, output rf_rdata[i].
- Scoreboard: one CW-bit counter per register. Register 0 is never written and is always 0.
- Issue: if iss_valid && !flush && iss_late && iss_waddr!=0, set counter[iss_waddr] <= LOAD_LAT on the next edge.
- Countdown: every edge with hold=0, each nonzero counter decrements by 1. With hold=1, all counters keep their value.
- Same-edge issue and countdown on the same register: the issue value wins (counter loads LOAD_LAT).
- Counters never wrap below 0.
- stallreq is combinational: OR over ports i of rd_en[i] && rd_addr[i]!=0 && counter[rd_addr[i]]!=0.
  - A matching forwarding source does not suppress stallreq while the counter is nonzero. The late value is not valid yet.
- The unit does not gate issue itself. iss_valid must be 0 whenever stallreq=1; the bench checks this as an assertion on the environment.
- A non-late issue to a register with a nonzero counter does not clear it. The counter runs out naturally, giving conservative stalls.
- stall_cycles increments on each edge where stallreq=1, saturating at 0xFFFFFFFF.
- flush has no effect on counters already set; only the same-cycle issue is dropped.
- Latency: an operand becomes stall-free exactly LOAD_LAT non-hold cycles after its producer's issue edge.

Test Plan:
1. Priority forwarding: rd_addr0=5, all three sources write r5 with 0x11/0x22/0x33 -> op_rdata0=0x11. Drop fwd_we[0] -> 0x22. Drop all -> rf_rdata0.
2. r0 handling: rd_addr=0, fwd source writes r0 with 0xDEAD, rf_rdata=0xBEEF -> op_rdata=0. iss_late to r0 -> busy_vec stays 0, no stall.
3. Load-use, LOAD_LAT=1: issue late r8. Next cycle rd_en0 with rd_addr0=8 -> stallreq=1 for exactly 1 cycle, stall_cycles=1. Following cycle stallreq=0 and op_rdata0 = MEM forward value.
4. hold interaction, LOAD_LAT=2: issue late r3, then hold=1 for 3 cycles -> stallreq stays 1 throughout. After hold drops, it clears after 2 more cycles; stall_cycles=5.
5. flush and same-edge reissue: iss_valid+iss_late+flush to r4 -> counter r4 stays 0. Separately, reissue r4 late the cycle its counter hits 1 -> counter reloads LOAD_LAT.
6. Async reset mid-operation: counters nonzero and stallreq=1, assert rst=0 between edges -> stallreq, busy_vec and stall_cycles go to 0 immediately, without waiting for a clock edge.
